// File: rtl/calc_seq_ctrl.sv
// Sequencing controller for the two-digit BCD add/subtract calculator: turns keypad
// events into operand digits, operator selection and display-mux controls.
module calc_seq_ctrl #(
    parameter logic [3:0] KEY_ADD = 4'd10,
    parameter logic [3:0] KEY_SUB = 4'd11,
    parameter logic [3:0] KEY_EQ  = 4'd14,
    parameter logic [3:0] KEY_CLR = 4'd15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_pressed,
    input  logic [3:0] key_code,
    output logic [3:0] a_tens,
    output logic [3:0] a_ones,
    output logic [3:0] b_tens,
    output logic [3:0] b_ones,
    output logic [3:0] reg0,
    output logic [3:0] reg1,
    output logic [3:0] reg2,
    output logic [3:0] reg3,
    output logic       add_en,
    output logic       sub_en,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        RESULT  = 2'd2
    } state_t;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_t;

    logic       kp_prev;
    logic       key_evt;
    logic [3:0] evt_code;

    state_t     cur_state, nxt_state;
    op_t        op_q, op_d, key_op;
    logic [3:0] a_tens_d, a_ones_d, b_tens_d, b_ones_d;
    logic [1:0] a_cnt, a_cnt_d, b_cnt, b_cnt_d;
    logic [3:0] reg0_d, reg1_d, reg2_d, reg3_d;
    logic       add_en_d, sub_en_d;
    logic       is_digit, is_op;

    // NOTE: kp_prev keeps following the key during rst so a key held through reset
    // is seen as already down and cannot fire an event until it is re-pressed.
    always_ff @(posedge clk) begin
        kp_prev  <= key_pressed;
        evt_code <= key_code;
        if (rst) begin
            key_evt <= 1'b0;
        end else begin
            key_evt <= key_pressed & ~kp_prev;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values; the combinational blocks below use blocking ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state <= ENTER_A;
            op_q      <= OP_ADD;
            a_tens    <= 4'd0;
            a_ones    <= 4'd0;
            b_tens    <= 4'd0;
            b_ones    <= 4'd0;
            a_cnt     <= 2'd0;
            b_cnt     <= 2'd0;
            reg0      <= 4'd0;
            reg1      <= 4'd0;
            reg2      <= 4'd0;
            reg3      <= 4'd0;
            add_en    <= 1'b1;
            sub_en    <= 1'b1;
        end else begin
            cur_state <= nxt_state;
            op_q      <= op_d;
            a_tens    <= a_tens_d;
            a_ones    <= a_ones_d;
            b_tens    <= b_tens_d;
            b_ones    <= b_ones_d;
            a_cnt     <= a_cnt_d;
            b_cnt     <= b_cnt_d;
            reg0      <= reg0_d;
            reg1      <= reg1_d;
            reg2      <= reg2_d;
            reg3      <= reg3_d;
            add_en    <= add_en_d;
            sub_en    <= sub_en_d;
        end
    end

    assign state = cur_state;

    // NOTE: every variable gets its hold value first so no path leaves one unassigned
    // and no latch is inferred.
    always_comb begin
        is_digit  = (evt_code <= 4'd9);
        is_op     = (evt_code == KEY_ADD) || (evt_code == KEY_SUB);
        key_op    = (evt_code == KEY_SUB) ? OP_SUB : OP_ADD;
        nxt_state = cur_state;
        op_d      = op_q;
        a_tens_d  = a_tens;
        a_ones_d  = a_ones;
        b_tens_d  = b_tens;
        b_ones_d  = b_ones;
        a_cnt_d   = a_cnt;
        b_cnt_d   = b_cnt;

        case (cur_state)
            ENTER_A: begin
                if (key_evt && is_digit && a_cnt < 2'd2) begin
                    a_tens_d = a_ones;
                    a_ones_d = evt_code;
                    a_cnt_d  = a_cnt + 2'd1;
                end else if (key_evt && is_op) begin
                    op_d      = key_op;
                    b_tens_d  = 4'd0;
                    b_ones_d  = 4'd0;
                    b_cnt_d   = 2'd0;
                    nxt_state = ENTER_B;
                end
            end
            ENTER_B: begin
                if (key_evt && is_digit && b_cnt < 2'd2) begin
                    b_tens_d = b_ones;
                    b_ones_d = evt_code;
                    b_cnt_d  = b_cnt + 2'd1;
                end else if (key_evt && is_op) begin
                    op_d = key_op;
                end else if (key_evt && evt_code == KEY_EQ) begin
                    nxt_state = RESULT;
                end
            end
            RESULT: begin
                // A new digit starts a fresh calculation; an operator chains on A.
                if (key_evt && is_digit) begin
                    a_tens_d  = 4'd0;
                    a_ones_d  = evt_code;
                    a_cnt_d   = 2'd1;
                    b_tens_d  = 4'd0;
                    b_ones_d  = 4'd0;
                    b_cnt_d   = 2'd0;
                    nxt_state = ENTER_A;
                end else if (key_evt && is_op) begin
                    op_d      = key_op;
                    b_tens_d  = 4'd0;
                    b_ones_d  = 4'd0;
                    b_cnt_d   = 2'd0;
                    nxt_state = ENTER_B;
                end
            end
            default: nxt_state = ENTER_A;
        endcase

        if (key_evt && evt_code == KEY_CLR) begin
            nxt_state = ENTER_A;
            op_d      = OP_ADD;
            a_tens_d  = 4'd0;
            a_ones_d  = 4'd0;
            b_tens_d  = 4'd0;
            b_ones_d  = 4'd0;
            a_cnt_d   = 2'd0;
            b_cnt_d   = 2'd0;
        end
    end

    // Display values are derived from the next state so they land on the same edge.
    always_comb begin
        if (nxt_state == ENTER_A) begin
            reg0_d = 4'd0;
            reg1_d = 4'd0;
            reg2_d = a_tens_d;
            reg3_d = a_ones_d;
        end else begin
            reg0_d = a_tens_d;
            reg1_d = a_ones_d;
            reg2_d = b_tens_d;
            reg3_d = b_ones_d;
        end
        add_en_d = !(nxt_state == RESULT && op_d == OP_ADD);
        sub_en_d = !(nxt_state == RESULT && op_d == OP_SUB);
    end

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Self-checking bench for calc_seq_ctrl: constant vector table, hand-written corner
// sequences and random key streams against a value-level calculator model.
module tb_calc_seq_ctrl;

    localparam logic [3:0] K_ADD = 4'd10;
    localparam logic [3:0] K_SUB = 4'd11;
    localparam logic [3:0] K_EQ  = 4'd14;
    localparam logic [3:0] K_CLR = 4'd15;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_pressed;
    logic [3:0] key_code;
    logic [3:0] a_tens, a_ones, b_tens, b_ones;
    logic [3:0] reg0, reg1, reg2, reg3;
    logic       add_en, sub_en;
    logic [1:0] state;

    int n_vec  = 0;
    int n_miss = 0;

    calc_seq_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .key_pressed(key_pressed),
        .key_code   (key_code),
        .a_tens     (a_tens),
        .a_ones     (a_ones),
        .b_tens     (b_tens),
        .b_ones     (b_ones),
        .reg0       (reg0),
        .reg1       (reg1),
        .reg2       (reg2),
        .reg3       (reg3),
        .add_en     (add_en),
        .sub_en     (sub_en),
        .state      (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] code;
        int         st;
        int         a;
        int         b;
        bit         ae;
        bit         se;
    } vec_t;

    // Calculator model: operands held as decimal values plus digit counts.
    int m_mode, m_a, m_an, m_b, m_bn;
    bit m_sub;

    task automatic model_clear();
        m_mode = 0; m_a = 0; m_an = 0; m_b = 0; m_bn = 0; m_sub = 1'b0;
    endtask

    task automatic model_key(input int code);
        if (code == 15) begin
            model_clear();
        end else if (code <= 9) begin
            if (m_mode == 0 && m_an < 2) begin
                m_a = (m_a % 10) * 10 + code; m_an++;
            end else if (m_mode == 1 && m_bn < 2) begin
                m_b = (m_b % 10) * 10 + code; m_bn++;
            end else if (m_mode == 2) begin
                m_a = code; m_an = 1; m_b = 0; m_bn = 0; m_mode = 0;
            end
        end else if (code == 10 || code == 11) begin
            m_sub = (code == 11);
            if (m_mode != 1) begin
                m_b = 0; m_bn = 0; m_mode = 1;
            end
        end else if (code == 14 && m_mode == 1) begin
            m_mode = 2;
        end
    endtask

    task automatic check_all(input string name, input int st, input int a, input int b,
                             input bit ae, input bit se);
        logic [3:0]  at, ao, bt, bo;
        logic [15:0] regs;
        logic [35:0] exp_v, act_v;
        at = 4'(a / 10); ao = 4'(a % 10);
        bt = 4'(b / 10); bo = 4'(b % 10);
        regs  = (st == 0) ? {8'h00, at, ao} : {at, ao, bt, bo};
        exp_v = {2'(st), at, ao, bt, bo, regs, ae, se};
        act_v = {state, a_tens, a_ones, b_tens, b_ones, reg0, reg1, reg2, reg3, add_en, sub_en};
        n_vec++;
        if (act_v !== exp_v) begin
            n_miss++;
            $display("FAIL %s: got st/a/b/regs/ae/se=%h expected %h", name, act_v, exp_v);
        end
    endtask

    task automatic check_model(input string name);
        check_all(name, m_mode, m_a, m_b, !(m_mode == 2 && !m_sub), !(m_mode == 2 && m_sub));
    endtask

    // Press and keep holding; outputs are settled at the returning negedge.
    task automatic press(input logic [3:0] code);
        @(negedge clk);
        key_pressed = 1'b1;
        key_code    = code;
        repeat (2) @(negedge clk);
    endtask

    task automatic release_key();
        key_pressed = 1'b0;
        key_code    = 4'($urandom);
        @(negedge clk);
    endtask

    task automatic tap(input logic [3:0] code);
        press(code);
        release_key();
    endtask

    vec_t tbl[$];

    initial begin
        rst = 1'b1; key_pressed = 1'b0; key_code = 4'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_all("reset", 0, 0, 0, 1'b1, 1'b1);

        tbl.push_back('{4'd1,  0,  1,  0, 1'b1, 1'b1});
        tbl.push_back('{4'd2,  0, 12,  0, 1'b1, 1'b1});
        tbl.push_back('{K_ADD, 1, 12,  0, 1'b1, 1'b1});
        tbl.push_back('{4'd3,  1, 12,  3, 1'b1, 1'b1});
        tbl.push_back('{4'd4,  1, 12, 34, 1'b1, 1'b1});
        tbl.push_back('{K_EQ,  2, 12, 34, 1'b0, 1'b1});
        tbl.push_back('{K_EQ,  2, 12, 34, 1'b0, 1'b1});
        tbl.push_back('{4'd6,  0,  6,  0, 1'b1, 1'b1});
        tbl.push_back('{K_ADD, 1,  6,  0, 1'b1, 1'b1});
        tbl.push_back('{4'd2,  1,  6,  2, 1'b1, 1'b1});
        tbl.push_back('{K_EQ,  2,  6,  2, 1'b0, 1'b1});
        tbl.push_back('{K_SUB, 1,  6,  0, 1'b1, 1'b1});
        tbl.push_back('{K_CLR, 0,  0,  0, 1'b1, 1'b1});
        tbl.push_back('{4'd5,  0,  5,  0, 1'b1, 1'b1});
        tbl.push_back('{K_SUB, 1,  5,  0, 1'b1, 1'b1});
        tbl.push_back('{4'd7,  1,  5,  7, 1'b1, 1'b1});
        tbl.push_back('{K_ADD, 1,  5,  7, 1'b1, 1'b1});
        tbl.push_back('{K_SUB, 1,  5,  7, 1'b1, 1'b1});
        tbl.push_back('{K_EQ,  2,  5,  7, 1'b1, 1'b0});
        tbl.push_back('{K_CLR, 0,  0,  0, 1'b1, 1'b1});
        tbl.push_back('{4'd9,  0,  9,  0, 1'b1, 1'b1});
        tbl.push_back('{4'd8,  0, 98,  0, 1'b1, 1'b1});
        tbl.push_back('{4'd7,  0, 98,  0, 1'b1, 1'b1});
        tbl.push_back('{4'd12, 0, 98,  0, 1'b1, 1'b1});
        tbl.push_back('{K_EQ,  0, 98,  0, 1'b1, 1'b1});
        tbl.push_back('{K_ADD, 1, 98,  0, 1'b1, 1'b1});
        tbl.push_back('{4'd13, 1, 98,  0, 1'b1, 1'b1});
        tbl.push_back('{4'd1,  1, 98,  1, 1'b1, 1'b1});
        tbl.push_back('{4'd2,  1, 98, 12, 1'b1, 1'b1});
        tbl.push_back('{4'd3,  1, 98, 12, 1'b1, 1'b1});

        for (int i = 0; i < tbl.size(); i++) begin
            press(tbl[i].code);
            check_all($sformatf("tbl[%0d]", i), tbl[i].st, tbl[i].a, tbl[i].b, tbl[i].ae, tbl[i].se);
            release_key();
        end

        // Two-cycle latency: unchanged after one edge, updated after the second.
        tap(K_CLR);
        @(negedge clk);
        key_pressed = 1'b1; key_code = 4'd1;
        @(negedge clk);
        check_all("latency_1cyc", 0, 0, 0, 1'b1, 1'b1);
        @(negedge clk);
        check_all("latency_2cyc", 0, 1, 0, 1'b1, 1'b1);
        release_key();

        // A key held for 50 cycles shifts exactly once.
        tap(K_CLR);
        @(negedge clk);
        key_pressed = 1'b1; key_code = 4'd3;
        repeat (50) @(negedge clk);
        check_all("held_key", 0, 3, 0, 1'b1, 1'b1);
        release_key();
        check_all("held_key_release", 0, 3, 0, 1'b1, 1'b1);

        // rst for one cycle in ENTER_B with a=45.
        tap(K_CLR); tap(4'd4); tap(4'd5); tap(K_ADD);
        check_all("pre_rst", 1, 45, 0, 1'b1, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all("mid_rst", 0, 0, 0, 1'b1, 1'b1);

        // Same with KEY_CLR.
        tap(4'd4); tap(4'd5); tap(K_SUB); tap(4'd1);
        check_all("pre_clr", 1, 45, 1, 1'b1, 1'b1);
        tap(K_CLR);
        check_all("mid_clr", 0, 0, 0, 1'b1, 1'b1);
        tap(4'd2); tap(K_ADD); tap(K_EQ);
        check_all("clr_op_is_add", 2, 2, 0, 1'b0, 1'b1);

        // A key held through reset release fires nothing until re-pressed.
        @(negedge clk);
        rst = 1'b1; key_pressed = 1'b1; key_code = 4'd7;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check_all("held_thru_rst", 0, 0, 0, 1'b1, 1'b1);
        release_key();
        tap(4'd7);
        check_all("repress_after_rst", 0, 7, 0, 1'b1, 1'b1);

        // Random key streams against the model.
        tap(K_CLR);
        model_clear();
        for (int i = 0; i < 400; i++) begin
            logic [3:0] code;
            code = ($urandom_range(0, 24) == 0) ? K_CLR : 4'($urandom_range(0, 14));
            model_key(int'(code));
            press(code);
            check_model($sformatf("rnd[%0d] code=%0d", i, code));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            release_key();
            repeat ($urandom_range(0, 1)) @(negedge clk);
            check_model($sformatf("rnd[%0d] idle", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/calc_seq_ctrl.md
Name: calc_seq_ctrl

Overview:
- Sequencing controller for the two-digit BCD add/subtract calculator.
- Takes keypad events and shifts digits into operand A and operand B; these operands feed the adder/subtractor datapath.
- Tracks the selected operator and drives the four display digit registers plus the add_en/sub_en select pair of the display mux.
- Sits between the keypad scanner and the adder/subtractor/display-mux datapath.

Parameters:
- KEY_ADD, 4'd10: key code selecting addition.
- KEY_SUB, 4'd11: key code selecting subtraction.
- KEY_EQ, 4'd14: key code requesting the result.
- KEY_CLR, 4'd15: key code clearing everything.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- key_pressed  input  1  level from keypad scanner, high while a key is held
- key_code  input  4  code of held key; valid while key_pressed=1
- a_tens  output  4  operand A tens digit (BCD)
- a_ones  output  4  operand A ones digit (BCD)
- b_tens  output  4  operand B tens digit (BCD)
- b_ones  output  4  operand B ones digit (BCD)
- reg0  output  4  display digit 0 (leftmost), entry view
- reg1  output  4  display digit 1, entry view
- reg2  output  4  display digit 2, entry view
- reg3  output  4  display digit 3 (rightmost), entry view
- add_en  output  1  display select, active-low for sum view
- sub_en  output  1  display select, active-low for difference view
- state  output  2  current FSM state, for LEDs

Behaviour:
- Clock and reset:
  - Single clock domain.
  - rst is synchronous and active-high; it is sampled on the rising clk edge and overrides every other input.
- Reset values:
  - State ENTER_A.
  - All operand and display digits 0.
  - Operator = ADD.
  - Digit counters 0.
  - add_en=1, sub_en=1 (entry view).
  - state=2'd0.
- Key event detection:
  - Register key_pressed and fire key_evt on the 0->1 transition only.
  - key_code is sampled in the cycle key_evt fires.
  - A held key produces exactly one event.
  - A key already held when rst deasserts produces no event until it is released and pressed again.
- Digit classification: code 0-9 is a digit; codes 12 and 13 are ignored everywhere.
- Digit entry, per operand:
  - digit_cnt (0..2) per operand.
  - On a digit with cnt<2: tens<=ones, ones<=code, cnt++.
  - On a digit with cnt==2: ignored; no wrap, no change.
- FSM states: ENTER_A=0, ENTER_B=1, RESULT=2; encoding 3 is unused and recovers to ENTER_A on the next clock.
- ENTER_A:
  - Digit: shift into A.
  - KEY_ADD/KEY_SUB: latch operator, clear B and its cnt, go to ENTER_B.
  - KEY_EQ: ignored.
- ENTER_B:
  - Digit: shift into B.
  - KEY_ADD/KEY_SUB: overwrite operator; B unchanged; stay.
  - KEY_EQ: go to RESULT.
- RESULT:
  - Digit: clear A, B and both cnts, load the digit as A ones (A cnt=1), go to ENTER_A.
  - KEY_ADD/KEY_SUB: keep A, clear B, latch operator, go to ENTER_B.
  - KEY_EQ: ignored.
- KEY_CLR: in any state, same effect as rst except the key edge detector is kept.
- Display outputs:
  - ENTER_A: reg0=0, reg1=0, reg2=a_tens, reg3=a_ones.
  - ENTER_B and RESULT: reg0=a_tens, reg1=a_ones, reg2=b_tens, reg3=b_ones.
- Display select:
  - RESULT with ADD: add_en=0, sub_en=1.
  - RESULT with SUB: add_en=1, sub_en=0.
  - All other states: add_en=1, sub_en=1.
  - The combination add_en=0, sub_en=0 is never driven.
- Output timing:
  - All outputs are registered.
  - Effect of a key is visible 2 clk cycles after the key_pressed rising edge: 1 cycle edge detect, 1 cycle update.
- Simultaneous events: rst beats key_evt; at most one key event per cycle by construction.

Test Plan:
- Reset then keys 1,2,KEY_ADD,3,4,KEY_EQ:
  - After 2: reg2=1, reg3=2.
  - After ADD: state=1, b_tens=0, b_ones=0.
  - After EQ: state=2, a=12, b=34, add_en=0, sub_en=1.
- Keys 5,KEY_SUB,7,KEY_ADD,KEY_SUB,KEY_EQ -> a_ones=5, b_ones=7, final add_en=1, sub_en=0.
- Keys 9,8,7 -> a_tens=9, a_ones=8; the third digit is ignored.
- key_pressed held high 50 cycles with code 3 -> a_ones=3 with a_tens=0, i.e. exactly one shift.
- From RESULT (a=12, b=34, ADD):
  - Digit 6 -> state=0, a_tens=0, a_ones=6, b=00, add_en=1, sub_en=1.
  - From a second RESULT, KEY_SUB -> state=1, A kept, b=00.
- Mid-entry rst and KEY_CLR:
  - rst asserted 1 cycle during ENTER_B with a=45 -> all digits 0, state=0 next cycle.
  - Same check repeated with KEY_CLR instead of rst.
